// File: rtl/averaging_filter.sv
// rtl/averaging_filter.sv - single-channel moving-average filter over the last 2^N samples
module averaging_filter #(
  parameter int DATA_W = 24,
  parameter int N      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              filter_en,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              primed
);

  localparam int DEPTH = 1 << N;

  typedef enum logic {PRIME, RUN} state_t;

  state_t            state_q, state_d;
  logic [N:0]        count_q, count_d;
  logic [N-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] scaled, oldest;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] hist_q [DEPTH];

  // Samples are stored pre-divided so the window sum is already the average.
  assign scaled = $signed(in_data) >>> N;
  assign oldest = hist_q[wr_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) state_q <= PRIME;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == PRIME && in_valid && count_q == (N+1)'(DEPTH - 1))
      state_d = RUN;
  end

  always_comb begin
    primed    = (state_q == RUN);
    out_valid = out_valid_q;
    out_data  = out_data_q;
  end

  always_comb begin
    acc_d      = acc_q + scaled - ((state_q == RUN) ? oldest : '0);
    wr_ptr_d   = wr_ptr_q + N'(1);
    count_d    = (state_q == PRIME) ? count_q + (N+1)'(1) : count_q;
    out_data_d = filter_en ? acc_d : in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (in_valid) begin
      acc_q       <= acc_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= 1'b1;
      out_data_q  <= out_data_d;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  // Oldest entry is read combinationally above, so this write is read-before-write.
  always_ff @(posedge clk) begin
    if (!reset && in_valid) hist_q[wr_ptr_q] <= scaled;
  end

endmodule

// File: tb/tb_averaging_filter.sv
// tb/tb_averaging_filter.sv - self-checking bench for averaging_filter (N=3, DATA_W=24)
module tb_averaging_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [23:0] in_data;
  logic        filter_en;
  logic        out_valid;
  logic [23:0] out_data;
  logic        primed;

  int n_vec = 0;
  int n_bad = 0;

  averaging_filter #(.DATA_W(24), .N(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .filter_en (filter_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: window of the last 8 floor(x/8) values, summed with plain integers.
  int          hist[$];
  int          accepted = 0;
  int          s, sum;
  logic [23:0] m_out = '0;
  logic        m_valid = 1'b0;
  logic        m_primed = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      accepted = 0;
      m_valid  = 1'b0;
      m_out    = '0;
      m_primed = 1'b0;
    end else if (in_valid) begin
      s = int'($signed(in_data)) >>> 3;
      hist.push_back(s);
      if (hist.size() > 8) void'(hist.pop_front());
      accepted++;
      sum = 0;
      foreach (hist[k]) sum += hist[k];
      m_out    = filter_en ? sum[23:0] : in_data;
      m_valid  = 1'b1;
      m_primed = (accepted >= 8);
    end else begin
      m_valid = 1'b0;
    end
    #1;
    chk("model_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("model_data", $signed(out_data), $signed(m_out));
    chk("model_primed", {31'b0, primed}, {31'b0, m_primed});
  end

  // Called at a negedge; returns at the next negedge with the result visible.
  task automatic send(input int d, input logic fe, input bit c, input int exp_d, input int exp_p, input string nm);
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = d[23:0];
    filter_en = fe;
    @(negedge clk);
    in_valid = 1'b0;
    if (c) begin
      chk({nm, "_valid"}, {31'b0, out_valid}, 1);
      chk(nm, $signed(out_data), exp_d);
      if (exp_p >= 0) chk({nm, "_primed"}, {31'b0, primed}, exp_p);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 24'($urandom);
      @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 0);
      chk("rst_data", $signed(out_data), 0);
      chk("rst_primed", {31'b0, primed}, 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_valid", {31'b0, out_valid}, 0);
    chk("rel_data", $signed(out_data), 0);
    chk("rel_primed", {31'b0, primed}, 0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    filter_en = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++)
      send(800, 1'b1, 1'b1, 100 * ((i < 8) ? i + 1 : 8), (i >= 7) ? 1 : 0, "ramp800");
    repeat (2) @(negedge clk);

    do_reset();
    for (int i = 0; i < 8; i++) send(0, 1'b1, 1'b1, 0, -1, "imp_prime");
    for (int r = 0; r < 3; r++) begin
      send(800, 1'b1, 1'b1, 100, 1, "imp_hit");
      for (int i = 0; i < 7; i++) send(0, 1'b1, 1'b1, 100, 1, "imp_tail");
      send(0, 1'b1, 1'b1, 0, 1, "imp_clear");
      @(negedge clk);
    end

    do_reset();
    for (int i = 0; i < 10; i++) send(-8, 1'b1, 1'b1, -((i < 8) ? i + 1 : 8), -1, "neg8");
    do_reset();
    for (int i = 0; i < 10; i++) send(7, 1'b1, 1'b1, 0, -1, "pos7");
    do_reset();
    for (int i = 0; i < 9; i++) send(-1, 1'b1, 1'b1, -((i < 8) ? i + 1 : 8), -1, "neg1");
    do_reset();
    for (int i = 0; i < 8; i++) send(32'h7FFFFF, 1'b1, 1'b1, (i + 1) * 1048575, -1, "fs_pos");
    do_reset();
    for (int i = 0; i < 8; i++) send(32'h800000, 1'b1, 1'b1, (i + 1) * -1048576, -1, "fs_neg");

    do_reset();
    for (int i = 1; i <= 16; i++)
      send(i, 1'(i % 2), (i % 2) == 0, i, -1, "bypass");
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 5; i++) send(800, 1'b1, 1'b1, 100 * (i + 1), 0, "pre800");
    do_reset();
    for (int i = 0; i < 8; i++) send(400, 1'b1, 1'b1, 50 * (i + 1), (i == 7) ? 1 : 0, "post400");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/averaging_filter.md
Name: averaging_filter

Overview:
- Single-channel moving-average (noise-reduction) filter between the audio CODEC read path and write path.
- Consumes one 24-bit signed sample per read handshake and produces the running average of the last 2^N samples for the CODEC write data.
- Top level instantiates two copies, one for the left channel and one for the right. The sample strobe is the same read/write handshake that advances the CODEC.

Parameters:
- DATA_W, 24, sample width in bits (two's complement), matching CODEC readdata/writedata.
- N, 3, log2 of window depth; window = 2^N samples (default 8).

Ports:
- clk  input  1  system clock (CLOCK_50 domain, same as CODEC)
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  one-cycle strobe: in_data holds a new sample (driven by read & write handshake)
- in_data  input  DATA_W  signed input sample (readdata_left or readdata_right)
- filter_en  input  1  1 = averaged output, 0 = bypass (registered passthrough)
- out_valid  output  1  one-cycle strobe: out_data updated
- out_data  output  DATA_W  signed filtered sample (to writedata_*)
- primed  output  1  high once 2^N samples have been accepted since reset

Behaviour:
- Reset (clk edge with reset=1) clears:
  - out_valid=0, out_data=0, primed=0
  - accumulator=0, write pointer=0, fill count=0
  - buffer contents are don't-care; they are never read before being written.
- Reset has priority over in_valid in the same cycle. A reset mid-stream discards all history, and the next sample starts priming from empty.
- Storage is a circular buffer of 2^N entries of DATA_W bits each, holding pre-scaled samples. It has a write pointer of N bits that wraps 2^N-1 -> 0, and a fill count from 0 to 2^N.
- Scaling:
  - scaled = in_data >>> N (arithmetic shift, sign-extended, floor rounding).
  - Example: 7 -> 0, -1 -> -1, -8 -> -1 for N=3.
- States:
  - PRIME (count < 2^N): on in_valid, acc <= acc + scaled; buffer[wr_ptr] <= scaled; wr_ptr++; count++.
  - PRIME -> RUN when count reaches 2^N; primed <= 1 in that same update.
  - RUN: on in_valid, acc <= acc + scaled - buffer[wr_ptr], where buffer[wr_ptr] is the oldest sample read before the overwrite. Then buffer[wr_ptr] <= scaled and wr_ptr++. RUN stays in RUN until reset.
- Accumulator is DATA_W bits, two's-complement modular arithmetic. The window sum of 2^N scaled values always fits in DATA_W, so no saturation is needed.
- Output timing:
  - On the cycle after in_valid, out_valid=1 for exactly one cycle.
  - out_data = new acc when filter_en=1, or the in_data captured with that strobe when filter_en=0.
  - Latency is 1 clk from in_valid to out_valid.
- In PRIME the output is the partial sum; it is not renormalised.
- filter_en is sampled on in_valid only. The history and accumulator update regardless of filter_en, so toggling it causes no transient.
- With no in_valid: no state change and out_data holds its last value.
- Back-to-back in_valid on consecutive cycles must be supported at one sample per clk. The buffer read and write of the same entry in one cycle must use the old value (read-before-write).

Test Plan:
- Reset check: assert reset for 2 clks with random in_valid/in_data -> out_valid=0, out_data=0, primed=0 throughout and on the first cycle after release.
- Constant input ramp: N=3, filter_en=1, 12 strobes of in_data=800 -> out_data sequence 100,200,...,800,800,800,800. primed rises with the 8th output. Each out_valid arrives exactly 1 clk after its strobe.
- Impulse and wrap-around: after priming with zeros, one sample of 800 then zeros -> out_data = 100 for 8 consecutive outputs, then 0. Repeat 3 times to exercise wr_ptr wrap.
- Sign and rounding: constant in_data=-8 gives -1,-2,...,-8 then -8. Constant in_data=7 gives 0 forever. Constant in_data=-1 gives -1..-8. Full-scale 0x7FFFFF and 0x800000 windows give 0x7FFFF8 and 0x800000 with no wrap error.
- Bypass and back-to-back: strobe in_valid every clk with a ramp 1,2,3,... while toggling filter_en each sample -> bypass outputs equal the input exactly. Averaged outputs equal the reference-model window sum, confirming history continuity.
- Reset mid-stream: after 5 samples of 800, pulse reset, then 8 samples of 400 -> outputs 50,100,...,400 with no residue from the earlier 800s; primed stays 0 until the 8th new sample.
